// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: multi-cycle HI/LO multiply/divide unit with start/busy/done handshake.
// Multiply commits after MUL_LATENCY cycles; divide is restoring radix-2 plus a sign-fix cycle.
module mips_muldiv_unit #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CMAX = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r, b_r, rem;
    logic             sgn, neg_q, neg_r;

    logic             accept, sa, sb, ge;
    logic [WIDTH-1:0] mag_a, mag_b, diff;
    logic [WIDTH:0]   shifted;
    logic [2*WIDTH-1:0] ax, bx, prod;

    always_comb begin
        accept  = op_valid && !busy && (op[2:1] != 2'b11);
        sa      = op[0] & src_a[WIDTH-1];
        sb      = op[0] & src_b[WIDTH-1];
        mag_a   = sa ? -src_a : src_a;
        mag_b   = sb ? -src_b : src_b;
        // a_r doubles as the dividend shift register; quotient bits enter at the bottom
        shifted = {rem, a_r[WIDTH-1]};
        ge      = shifted >= {1'b0, b_r};
        diff    = shifted[WIDTH-1:0] - b_r;
        ax      = {{WIDTH{sgn & a_r[WIDTH-1]}}, a_r};
        bx      = {{WIDTH{sgn & b_r[WIDTH-1]}}, b_r};
        prod    = ax * bx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            rem   <= '0;
            sgn   <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cancel && busy) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        if (op[2]) begin
                            if (op[0]) lo <= src_a;
                            else       hi <= src_a;
                            done <= 1'b1;
                        end else if (!op[1]) begin
                            state <= MUL;
                            busy  <= 1'b1;
                            cnt   <= CW'(MUL_LATENCY - 1);
                            a_r   <= src_a;
                            b_r   <= src_b;
                            sgn   <= op[0];
                        end else if (src_b == '0) begin
                            hi   <= src_a;
                            lo   <= '1;
                            done <= 1'b1;
                        end else begin
                            state <= DIV;
                            busy  <= 1'b1;
                            cnt   <= CW'(WIDTH - 1);
                            a_r   <= mag_a;
                            b_r   <= mag_b;
                            rem   <= '0;
                            neg_q <= sa ^ sb;
                            neg_r <= sa;
                        end
                    end
                    MUL: if (cnt == '0) begin
                        {hi, lo} <= prod;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                    DIV: begin
                        rem   <= ge ? diff : shifted[WIDTH-1:0];
                        a_r   <= {a_r[WIDTH-2:0], ge};
                        cnt   <= cnt - 1'b1;
                        state <= (cnt == '0) ? FIX : DIV;
                    end
                    FIX: begin
                        lo    <= neg_q ? -a_r : a_r;
                        hi    <= neg_r ? -rem : rem;
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit: directed checks of multiply/divide/move, latency, cancel and reset.
module tb_mips_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        cancel = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int total = 0;
    int bad = 0;

    mips_muldiv_unit #(.WIDTH(32), .MUL_LATENCY(4)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_valid = 1'b1;
        op = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("reset_hilo", {hi, lo}, 64'h0);
        check("reset_busy_done", {62'h0, busy, done}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        go(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_busy1", {63'h0, busy}, 64'h1);
        step(3);
        check("multu_busy4", {63'h0, busy}, 64'h1);
        check("multu_no_partial", {hi, lo}, 64'h0);
        step(1);
        check("multu_result", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        check("multu_done", {62'h0, busy, done}, 64'h1);
        step(1);
        check("multu_done_pulse", {63'h0, done}, 64'h0);

        go(3'b001, 32'hFFFF_FFFE, 32'h0000_0003);
        step(4);
        check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

        go(3'b001, 32'h8000_0000, 32'h8000_0000);
        step(4);
        check("mult_minmin", {hi, lo}, 64'h4000_0000_0000_0000);

        go(3'b011, 32'hFFFF_FFF9, 32'h0000_0002);
        step(32);
        check("div_busy_k32", {63'h0, busy}, 64'h1);
        check("div_no_partial", {hi, lo}, 64'h4000_0000_0000_0000);
        step(1);
        check("div_neg7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        check("div_done", {62'h0, busy, done}, 64'h1);

        go(3'b010, 32'd100, 32'd7);
        step(33);
        check("divu_100_7", {hi, lo}, {32'd2, 32'd14});

        go(3'b010, 32'd5, 32'd0);
        check("divu_by_zero", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        check("divu_by_zero_busy", {63'h0, busy}, 64'h0);

        go(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
        step(33);
        check("div_min_neg1", {hi, lo}, {32'h0, 32'h8000_0000});

        go(3'b100, 32'h0000_1234, 32'h0);
        check("mthi", {hi, lo}, {32'h1234, 32'h8000_0000});
        check("mthi_done", {62'h0, busy, done}, 64'h1);
        go(3'b101, 32'h0000_5678, 32'h0);
        check("mtlo", {hi, lo}, {32'h1234, 32'h5678});

        go(3'b010, 32'd100, 32'd7);
        step(5);
        go(3'b001, 32'd3, 32'd4);
        step(27);
        check("busy_ignore_result", {hi, lo}, {32'd2, 32'd14});
        check("busy_ignore_idle", {63'h0, busy}, 64'h0);
        step(4);
        check("busy_ignore_nomul", {hi, lo}, {32'd2, 32'd14});

        go(3'b001, 32'd3, 32'd4);
        @(negedge clk);
        cancel = 1'b1;
        step(1);
        cancel = 1'b0;
        check("cancel_busy", {62'h0, busy, done}, 64'h0);
        step(1);
        check("cancel_no_done", {63'h0, done}, 64'h0);
        step(3);
        check("cancel_hilo", {hi, lo}, {32'd2, 32'd14});

        @(negedge clk);
        cancel = 1'b1;
        go(3'b100, 32'h0000_ABCD, 32'h0);
        cancel = 1'b0;
        check("cancel_idle_accept", {hi, lo}, {32'hABCD, 32'd14});

        go(3'b011, 32'd1000, 32'd3);
        step(10);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_hilo", {hi, lo}, 64'h0);
        check("reset_mid_busy", {62'h0, busy, done}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        go(3'b001, 32'd3, 32'd4);
        step(4);
        check("after_reset_mult", {hi, lo}, 64'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
